// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions: opcodes, instruction field positions, nop word
// and the MDU sequencer state type.
package simplerisc_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam logic [31:0] NOP_INSTR = 32'h6800_0000;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int IMM_BIT = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 22;
  localparam int RS1_MSB = 21;
  localparam int RS1_LSB = 18;
  localparam int RS2_MSB = 17;
  localparam int RS2_LSB = 14;

  // ret implicitly reads the return-address register
  localparam logic [3:0] RA_REG = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_mdu_op(input logic [4:0] opcode);
    return (opcode == OP_MUL) || (opcode == OP_DIV) || (opcode == OP_MOD);
  endfunction

endpackage

// File: rtl/mdu_seq_fsm.sv
// MDU occupancy sequencer: holds a mul/div/mod in EX for its full latency and
// reports when the front of the pipe must stall.
module mdu_seq_fsm
  import simplerisc_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode_e,
  output logic       stall_mdu,
  output logic       mdu_start,
  output logic       mdu_busy
);

  // Countdown seeds: the IDLE cycle and the final release cycle are not counted.
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] DIV_CNT_INIT = (DIV_LAT > 1) ? CNT_W'(DIV_LAT - 2) : '0;

  mdu_state_e       r_state;
  mdu_state_e       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;

  logic w_is_mul;
  logic w_is_div;
  logic w_multi_cycle;

  assign w_is_mul      = (opcode_e == OP_MUL);
  assign w_is_div      = (opcode_e == OP_DIV) || (opcode_e == OP_MOD);
  assign w_multi_cycle = (w_is_mul && (MUL_LAT > 1)) || (w_is_div && (DIV_LAT > 1));

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // NOTE: every output is defaulted first so no path through the case infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    stall_mdu    = 1'b0;
    mdu_start    = 1'b0;
    mdu_busy     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (is_mdu_op(opcode_e)) begin
          mdu_start = 1'b1;
          if (w_multi_cycle) begin
            stall_mdu    = 1'b1;
            mdu_busy     = 1'b1;
            w_next_cnt   = w_is_mul ? MUL_CNT_INIT : DIV_CNT_INIT;
            w_next_state = BUSY;
          end
        end
      end
      BUSY: begin
        mdu_busy = 1'b1;
        if (r_cnt != '0) begin
          stall_mdu  = 1'b1;
          w_next_cnt = r_cnt - CNT_W'(1);
        end else begin
          // op advances out of EX on this edge
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase

    if (rst) begin
      stall_mdu = 1'b0;
      mdu_start = 1'b0;
      mdu_busy  = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_interlock_ctrl.sv
// Stall/bubble/flush sequencer for the 5-stage SimpleRISC pipeline.
// Optional perf counters are built only when PERF_CNT_EN is defined.
module pipeline_interlock_ctrl
  import simplerisc_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_of,
  input  logic [31:0] instruction_e,
  input  logic        isBranchTaken_E,
  output logic        stall_IF,
  output logic        stall_OF,
  output logic        stall_E,
  output logic        bubble_E,
  output logic        bubble_M,
  output logic        flush_OF,
  output logic        mdu_start,
  output logic        mdu_busy,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  logic [4:0] w_op_of;
  logic [4:0] w_op_e;
  logic       w_imm_of;
  logic [3:0] w_rs1_of;
  logic [3:0] w_rs2_of;
  logic [3:0] w_rd_e;
  logic       w_uses_rs1;
  logic       w_uses_rs2;
  logic       w_is_ret;
  logic       w_load_use;
  logic       w_stall_mdu;
  logic       w_unused_bits;

  assign w_op_of  = instruction_of[OPC_MSB:OPC_LSB];
  assign w_imm_of = instruction_of[IMM_BIT];
  assign w_rs1_of = instruction_of[RS1_MSB:RS1_LSB];
  assign w_rs2_of = instruction_of[RS2_MSB:RS2_LSB];
  assign w_op_e   = instruction_e[OPC_MSB:OPC_LSB];
  assign w_rd_e   = instruction_e[RD_MSB:RD_LSB];

  // Fields the interlock never inspects.
  assign w_unused_bits = ^{instruction_of[RD_MSB:RD_LSB], instruction_of[13:0],
                           instruction_e[IMM_BIT], instruction_e[RS1_MSB:0]};

  // st's data register (rd) is intentionally ignored: RW->MA forwarding covers it.
  assign w_uses_rs1 = ((w_op_of <= OP_ASR) && (w_op_of != OP_NOT) && (w_op_of != OP_MOV))
                    || (w_op_of == OP_LD) || (w_op_of == OP_ST);
  assign w_uses_rs2 = !w_imm_of && (w_op_of <= OP_ASR);
  assign w_is_ret   = (w_op_of == OP_RET);

  assign w_load_use = (w_op_e == OP_LD) &&
                      ((w_uses_rs1 && (w_rs1_of == w_rd_e)) ||
                       (w_uses_rs2 && (w_rs2_of == w_rd_e)) ||
                       (w_is_ret   && (w_rd_e   == RA_REG)));

  mdu_seq_fsm #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_mdu_seq_fsm (
    .clk       (clk),
    .rst       (rst),
    .opcode_e  (w_op_e),
    .stall_mdu (w_stall_mdu),
    .mdu_start (mdu_start),
    .mdu_busy  (mdu_busy)
  );

  // Priority: rst > taken-branch flush > MDU stall > load-use.
  always_comb begin
    stall_IF = 1'b0;
    stall_OF = 1'b0;
    stall_E  = 1'b0;
    bubble_E = 1'b0;
    bubble_M = 1'b0;
    flush_OF = 1'b0;

    if (rst) begin
      // everything stays low
    end else if (isBranchTaken_E) begin
      flush_OF = 1'b1;
      bubble_E = 1'b1;
    end else if (w_stall_mdu) begin
      stall_IF = 1'b1;
      stall_OF = 1'b1;
      stall_E  = 1'b1;
      bubble_M = 1'b1;
    end else if (w_load_use) begin
      stall_IF = 1'b1;
      stall_OF = 1'b1;
      bubble_E = 1'b1;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (stall_IF) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (flush_OF) r_flush_count  <= r_flush_count + 32'd1;
    end
  end

  assign stall_cycles = rst ? 32'h0 : r_stall_cycles;
  assign flush_count  = rst ? 32'h0 : r_flush_count;
`else
  assign stall_cycles = 32'h0;
  assign flush_count  = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_interlock_ctrl.sv
// Directed bench for pipeline_interlock_ctrl: load-use, MDU sequencing, branch
// flush, mid-sequence reset and perf counters (PERF_CNT_EN optional).
module tb_pipeline_interlock_ctrl;

  localparam logic [4:0] T_ADD = 5'b00000;
  localparam logic [4:0] T_MUL = 5'b00010;
  localparam logic [4:0] T_DIV = 5'b00011;
  localparam logic [4:0] T_NOT = 5'b01000;
  localparam logic [4:0] T_MOV = 5'b01001;
  localparam logic [4:0] T_LD  = 5'b01110;
  localparam logic [4:0] T_ST  = 5'b01111;
  localparam logic [4:0] T_RET = 5'b10100;
  localparam logic [31:0] T_NOP = 32'h6800_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction_of;
  logic [31:0] instruction_e;
  logic        isBranchTaken_E;

  logic stall_IF, stall_OF, stall_E, bubble_E, bubble_M, flush_OF, mdu_start, mdu_busy;
  logic [31:0] stall_cycles, flush_count;

  logic l1_stall_IF, l1_stall_OF, l1_stall_E, l1_bubble_E, l1_bubble_M, l1_flush_OF;
  logic l1_mdu_start, l1_mdu_busy;
  logic [31:0] l1_stall_cycles, l1_flush_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_interlock_ctrl #(.MUL_LAT(3), .DIV_LAT(8), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .instruction_of(instruction_of), .instruction_e(instruction_e),
    .isBranchTaken_E(isBranchTaken_E), .stall_IF(stall_IF), .stall_OF(stall_OF),
    .stall_E(stall_E), .bubble_E(bubble_E), .bubble_M(bubble_M), .flush_OF(flush_OF),
    .mdu_start(mdu_start), .mdu_busy(mdu_busy), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  pipeline_interlock_ctrl #(.MUL_LAT(1), .DIV_LAT(8), .CNT_W(4)) u_dut_l1 (
    .clk(clk), .rst(rst), .instruction_of(instruction_of), .instruction_e(instruction_e),
    .isBranchTaken_E(isBranchTaken_E), .stall_IF(l1_stall_IF), .stall_OF(l1_stall_OF),
    .stall_E(l1_stall_E), .bubble_E(l1_bubble_E), .bubble_M(l1_bubble_M),
    .flush_OF(l1_flush_OF), .mdu_start(l1_mdu_start), .mdu_busy(l1_mdu_busy),
    .stall_cycles(l1_stall_cycles), .flush_count(l1_flush_count)
  );

  function automatic logic [31:0] enc(input logic [4:0] op, input logic imm,
                                      input logic [3:0] rd, input logic [3:0] rs1,
                                      input logic [3:0] rs2);
    return {op, imm, rd, rs1, rs2, 14'd0};
  endfunction

  // {stall_IF, stall_OF, stall_E, bubble_E, bubble_M, flush_OF, mdu_start, mdu_busy}
  function automatic logic [7:0] outs();
    return {stall_IF, stall_OF, stall_E, bubble_E, bubble_M, flush_OF, mdu_start, mdu_busy};
  endfunction

  function automatic logic [7:0] l1_outs();
    return {l1_stall_IF, l1_stall_OF, l1_stall_E, l1_bubble_E, l1_bubble_M, l1_flush_OF,
            l1_mdu_start, l1_mdu_busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled 2 units later.
  task automatic drive(input logic [31:0] of_i, input logic [31:0] e_i, input logic br);
    instruction_of  = of_i;
    instruction_e   = e_i;
    isBranchTaken_E = br;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ld_r3, ld_r15, add_r5_r3_r2, add_r5_r2_r3, addi_r5_r2, st_r3_r4;
  logic [31:0] mov_r1_r3, noti_r1, ret_i, mul_r4, div_r7, add_r6_r4_r1;
  int          n_stall;
  logic        released;

  initial begin
    ld_r3        = enc(T_LD,  1'b1, 4'd3,  4'd1, 4'd0);
    ld_r15       = enc(T_LD,  1'b1, 4'd15, 4'd1, 4'd0);
    add_r5_r3_r2 = enc(T_ADD, 1'b0, 4'd5,  4'd3, 4'd2);
    add_r5_r2_r3 = enc(T_ADD, 1'b0, 4'd5,  4'd2, 4'd3);
    addi_r5_r2   = enc(T_ADD, 1'b1, 4'd5,  4'd2, 4'd3);
    st_r3_r4     = enc(T_ST,  1'b1, 4'd3,  4'd4, 4'd0);
    mov_r1_r3    = enc(T_MOV, 1'b0, 4'd1,  4'd0, 4'd3);
    noti_r1      = enc(T_NOT, 1'b1, 4'd1,  4'd0, 4'd3);
    ret_i        = enc(T_RET, 1'b0, 4'd0,  4'd0, 4'd0);
    mul_r4       = enc(T_MUL, 1'b0, 4'd4,  4'd1, 4'd2);
    div_r7       = enc(T_DIV, 1'b0, 4'd7,  4'd1, 4'd2);
    add_r6_r4_r1 = enc(T_ADD, 1'b0, 4'd6,  4'd4, 4'd1);

    // Reset state and reset overriding a live hazard
    rst = 1'b1;
    drive(T_NOP, T_NOP, 1'b0);
    check("reset_outs", outs(), 8'h00);
    next_cycle();
    drive(add_r5_r3_r2, ld_r3, 1'b1);
    check("rst_forces_zero", outs(), 8'h00);
    check("reset_stall_cycles", stall_cycles, 32'h0);
    check("reset_flush_count", flush_count, 32'h0);
    next_cycle();
    rst = 1'b0;

    // Load-use on rs1, then release once the ld has left EX
    drive(add_r5_r3_r2, ld_r3, 1'b0);
    check("lu_rs1", outs(), 8'hD0);
    next_cycle();
    drive(add_r5_r3_r2, T_NOP, 1'b0);
    check("lu_release", outs(), 8'h00);
    drive(st_r3_r4, ld_r3, 1'b0);
    check("lu_st_data_no_stall", outs(), 8'h00);
    drive(add_r5_r2_r3, ld_r3, 1'b0);
    check("lu_rs2", outs(), 8'hD0);
    drive(addi_r5_r2, ld_r3, 1'b0);
    check("lu_imm_no_rs2", outs(), 8'h00);
    drive(mov_r1_r3, ld_r3, 1'b0);
    check("lu_mov_rs2", outs(), 8'hD0);
    drive(noti_r1, ld_r3, 1'b0);
    check("lu_not_imm", outs(), 8'h00);
    drive(ret_i, ld_r15, 1'b0);
    check("lu_ret_r15", outs(), 8'hD0);
    drive(add_r5_r3_r2, enc(T_ADD, 1'b0, 4'd3, 4'd1, 4'd2), 1'b0);
    check("non_ld_no_stall", outs(), 8'h00);
    drive(enc(T_ADD, 1'b0, 4'd5, 4'd0, 4'd0), T_NOP, 1'b0);
    check("nop_in_ex", outs(), 8'h00);
    next_cycle();

    // mul, MUL_LAT=3 (and MUL_LAT=1 instance sees the same op)
    drive(add_r6_r4_r1, mul_r4, 1'b0);
    check("mul_c1", outs(), 8'hEB);
    check("mul_l1_start_only", l1_outs(), 8'h02);
    next_cycle();
    drive(add_r6_r4_r1, mul_r4, 1'b0);
    check("mul_c2", outs(), 8'hE9);
    next_cycle();
    drive(add_r6_r4_r1, mul_r4, 1'b0);
    check("mul_c3", outs(), 8'h01);
    next_cycle();
    drive(add_r6_r4_r1, T_NOP, 1'b0);
    check("mul_idle", outs(), 8'h00);
    next_cycle();

    // div, DIV_LAT=8: seven stall cycles, release on the eighth
    n_stall  = 0;
    released = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(add_r6_r4_r1, div_r7, 1'b0);
      if (i == 0) check("div_start", {31'd0, mdu_start}, 32'd1);
      if (stall_E) begin
        n_stall++;
        next_cycle();
      end else begin
        released = 1'b1;
        break;
      end
    end
    check("div_released", {31'd0, released}, 32'd1);
    check("div_stall_cycles", n_stall, 32'd7);
    check("div_release_outs", outs(), 8'h01);
    next_cycle();
    drive(add_r6_r4_r1, T_NOP, 1'b0);
    check("div_idle", outs(), 8'h00);
    next_cycle();

    // Taken branch overrides a matching load-use
    drive(add_r5_r3_r2, ld_r3, 1'b1);
    check("branch_flush", outs(), 8'h14);
    next_cycle();
    drive(add_r5_r3_r2, T_NOP, 1'b0);
    check("branch_one_cycle", outs(), 8'h00);
    next_cycle();

    // Reset in the 4th cycle of a div, then a fresh mul
    for (int i = 0; i < 3; i++) begin
      drive(add_r6_r4_r1, div_r7, 1'b0);
      next_cycle();
    end
    rst = 1'b1;
    drive(add_r6_r4_r1, div_r7, 1'b0);
    check("rst_mid_div", outs(), 8'h00);
    next_cycle();
    rst = 1'b0;
    drive(add_r6_r4_r1, T_NOP, 1'b0);
    check("post_rst_idle", outs(), 8'h00);
    next_cycle();
    drive(add_r6_r4_r1, mul_r4, 1'b0);
    check("mul_after_rst_c1", outs(), 8'hEB);
    next_cycle();
    drive(add_r6_r4_r1, mul_r4, 1'b0);
    check("mul_after_rst_c2", outs(), 8'hE9);
    next_cycle();
    drive(add_r6_r4_r1, mul_r4, 1'b0);
    check("mul_after_rst_c3", outs(), 8'h01);
    next_cycle();

    // Perf counters: mul (2 stall cycles) + load-use (1) + two taken branches
    rst = 1'b1;
    drive(T_NOP, T_NOP, 1'b0);
    check("perf_rst_zero", stall_cycles, 32'h0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(add_r6_r4_r1, mul_r4, 1'b0);
      next_cycle();
    end
    drive(add_r5_r3_r2, T_NOP, 1'b0);
    next_cycle();
    drive(add_r5_r3_r2, ld_r3, 1'b0);
    next_cycle();
    drive(add_r5_r3_r2, T_NOP, 1'b0);
    next_cycle();
    drive(add_r5_r3_r2, T_NOP, 1'b1);
    next_cycle();
    drive(add_r5_r3_r2, T_NOP, 1'b1);
    next_cycle();
    drive(add_r5_r3_r2, T_NOP, 1'b0);
`ifdef PERF_CNT_EN
    check("perf_stall_cycles", stall_cycles, 32'd3);
    check("perf_flush_count", flush_count, 32'd2);
`else
    check("perf_stall_cycles", stall_cycles, 32'd0);
    check("perf_flush_count", flush_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_interlock_ctrl.md
Name: pipeline_interlock_ctrl

Overview:
- Stall, bubble and flush sequencer for the 5-stage SimpleRISC pipeline (IF, OF, EX, MA, RW).
- Works alongside the forwarding unit and covers the hazards that forwarding cannot resolve:
  - load-use in OF;
  - multi-cycle mul/div/mod occupying EX;
  - taken-branch flush.
- Drives the hold and nop-insert controls of the PC and of the IF/OF, OF/EX and EX/MA latches.

Parameters:
MUL_LAT, 3, total EX cycles for mul (>=1)
DIV_LAT, 8, total EX cycles for div/mod (>=1)
CNT_W, 4, MDU countdown width; must hold max(MUL_LAT,DIV_LAT)-2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instruction_of  in  32  instruction in OF stage
instruction_e  in  32  instruction in EX stage
isBranchTaken_E  in  1  branch in EX resolved taken
stall_IF  out  1  hold PC
stall_OF  out  1  hold IF/OF latch
stall_E  out  1  hold OF/EX latch
bubble_E  out  1  load nop into OF/EX latch
bubble_M  out  1  load nop into EX/MA latch
flush_OF  out  1  load nop into IF/OF latch
mdu_start  out  1  one-cycle pulse: MDU op entered EX
mdu_busy  out  1  MDU sequence in progress
stall_cycles  out  32  perf counter (see Optional Feature)
flush_count  out  32  perf counter (see Optional Feature)

Behaviour:
- Clock, reset and fields:
  - One clock domain. Reset is synchronous and active-high; ports are named clk and rst.
  - Instruction fields: opcode [31:27], I [26], rd [25:22], rs1 [21:18], rs2 [17:14].
  - nop word = 32'h6800_0000 (opcode 01101).
- Reset: state=IDLE, cnt=0, all outputs 0, perf counters 0. When rst=1 all outputs are forced 0 in that same cycle, including mid-MDU.
- Source-use decode for the OF instruction:
  - rs1 is used by add, sub, mul, div, mod, cmp, and, or, lsl, lsr, asr, ld, st.
  - rs2 is used when I=0 by add..asr plus not and mov.
  - ret reads r15.
  - The st data register (rd field) never triggers a stall; it is covered by RW->MA forwarding.
- Load-use (combinational):
  - Condition: EX opcode=ld (01110), and ld rd equals a used OF source.
  - Response: stall_IF=stall_OF=1, bubble_E=1 for exactly 1 cycle. After that the ld has left EX, so there is no repeat.
- MDU FSM, states IDLE and BUSY:
  - Let L = MUL_LAT for mul (00010), DIV_LAT for div (00011) or mod (00100).
  - IDLE, EX holds an MDU op:
    - mdu_start=1 every time.
    - If L>1: stall_IF=stall_OF=stall_E=1, bubble_M=1, mdu_busy=1, cnt<=L-2, next=BUSY.
    - If L==1: no stall, stay IDLE.
  - BUSY, cnt!=0: same four stalls + bubble_M, mdu_busy=1, cnt<=cnt-1.
  - BUSY, cnt==0: stalls released, mdu_busy=1, next=IDLE. The op advances at this edge.
  - Net effect: an MDU op spends exactly L cycles in EX and generates L-1 bubbles into MA.
  - mdu_start never re-fires for the same instruction. The return to IDLE coincides with the op leaving EX.
- Branch:
  - isBranchTaken_E=1 gives flush_OF=1 and bubble_E=1 for 1 cycle. No stall.
  - Load-use detection is suppressed that cycle because the OF instruction is killed.
- Priority: rst > branch flush > MDU stall > load-use. MDU and load-use cannot coincide (single EX occupant), but both are still coded with this priority.
- A nop or bubble in EX never triggers anything.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined:
  - stall_cycles increments on every cycle with stall_IF=1.
  - flush_count increments on every cycle with flush_OF=1.
  - Both are 32-bit, wrap at 2^32-1 -> 0, and clear on rst.
- Undefined: both outputs are tied to 32'h0 and no counter flops are generated. Ports are present in both builds.

Decomposition:
- Shared package simplerisc_pkg holds:
  - opcode constants (OP_MUL, OP_DIV, OP_MOD, OP_LD, OP_ST, OP_NOP, OP_RET, ...);
  - NOP_INSTR;
  - field bit-position constants;
  - FSM state typedef {IDLE, BUSY}.
- One sub-module, mdu_seq_fsm: the MDU state machine and countdown. It takes opcode_e and gives stall_mdu, mdu_start, mdu_busy.
- Hazard decode and priority muxing remain in the top level.

Test Plan:
- EX=ld r3,[r1], OF=add r5,r3,r2 -> one cycle stall_IF=stall_OF=bubble_E=1, then all 0. Also check: OF=st r3,[r4] -> no stall.
- EX=mul r4,r1,r2 with MUL_LAT=3 -> mdu_start pulses on cycle 1; stall_E=bubble_M=1 on cycles 1-2; released on cycle 3; mdu_busy high on cycles 1-3.
- EX=div with DIV_LAT=8 -> exactly 7 stall cycles, then IDLE. Repeat with MUL_LAT=1 -> mdu_start pulse only, no stall.
- isBranchTaken_E=1 while EX ld matches OF source -> flush_OF=bubble_E=1, stall_IF=0.
- rst asserted during BUSY cycle 4 of div -> next cycle all outputs 0, state IDLE; a new mul is accepted normally afterward.
- With PERF_CNT_EN: mul (L=3) + load-use + 2 taken branches -> stall_cycles=3, flush_count=2. Without the macro -> both read 0.
